// File: rtl/async_fifo_unpacker_if.sv
// async_fifo_unpacker_if: FIFO read port plus slice stream bundle for the unpacker
// master: unpacker side (drives fifo_read_en, out_valid, out_data, out_last)
// slave:  surrounding side (drives fifo_empty, fifo_read_data, out_ready)
interface async_fifo_unpacker_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
);
  logic                 fifo_empty;
  logic [IN_WIDTH-1:0]  fifo_read_data;
  logic                 fifo_read_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_read_en, out_valid, out_data, out_last
  );
  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_read_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/async_fifo_unpacker.sv
// async_fifo_unpacker: pops wide FIFO words and streams them as narrow slices
// Ports: read_clk (clock), read_reset_n (sync active-low reset), flush (drop held word),
//   bus.master: fifo_empty/fifo_read_data/fifo_read_en (FWFT read port),
//   out_valid/out_ready/out_data/out_last (slice stream).
// Define ASYNC_FIFO_UNPACK_MSB_FIRST_EN to emit the most-significant slice first.
module async_fifo_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic read_clk,
  input  logic read_reset_n,
  input  logic flush,
  async_fifo_unpacker_if.master bus
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO);
  logic                h;
  logic [IN_WIDTH-1:0] word_reg;
  logic [IDX_W-1:0]    slice_idx;
  logic [IDX_W-1:0]    sel;
  logic                accept;
  logic                drain;
  logic                load;
  assign accept           = h & bus.out_ready;
  assign bus.out_last     = h & (slice_idx == IDX_W'(RATIO - 1));
  assign drain            = accept & bus.out_last;
  // A new word loads in the same cycle the last slice leaves, so words stream bubble-free.
  assign load             = !bus.fifo_empty & read_reset_n & !flush & (!h | drain);
  assign bus.fifo_read_en = load;
  assign bus.out_valid    = h;
`ifdef ASYNC_FIFO_UNPACK_MSB_FIRST_EN
  // RATIO is a power of two, so RATIO-1-k is the bitwise inverse of k.
  assign sel = ~slice_idx;
`else
  assign sel = slice_idx;
`endif
  assign bus.out_data = word_reg[sel*OUT_WIDTH +: OUT_WIDTH];
  always_ff @(posedge read_clk) begin
    if (!read_reset_n) begin
      h         <= 1'b0;
      slice_idx <= '0;
      word_reg  <= '0;
    end else if (flush) begin
      h         <= 1'b0;
      slice_idx <= '0;
    end else if (load) begin
      h         <= 1'b1;
      slice_idx <= '0;
      word_reg  <= bus.fifo_read_data;
    end else if (drain) begin
      h <= 1'b0;
    end else if (accept) begin
      slice_idx <= slice_idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_async_fifo_unpacker.sv
// tb_async_fifo_unpacker: directed self-checking bench for async_fifo_unpacker
module tb_async_fifo_unpacker;
  typedef struct packed {
    logic        r;
    logic        f;
    logic        n;
    logic        v;
    logic        l;
    logic        re;
    logic [31:0] w;
    logic [1:0]  k;
  } cyc_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic [31:0] mem [0:15];
  int          rd = 0;
  int          wr = 0;
  int          checks = 0;
  int          errors = 0;
  async_fifo_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus ();
  async_fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .read_clk(clk), .read_reset_n(rst_n), .flush(flush), .bus(bus.master)
  );
  always #5 clk = ~clk;
  assign bus.fifo_empty     = (rd == wr);
  assign bus.fifo_read_data = mem[rd % 16];
  always @(posedge clk) if (bus.fifo_read_en) rd <= rd + 1;

  function automatic logic [7:0] sl(input logic [31:0] w, input logic [1:0] k);
    logic [31:0] x;
`ifdef ASYNC_FIFO_UNPACK_MSB_FIRST_EN
    x = w >> (8 * (3 - k));
`else
    x = w >> (8 * k);
`endif
    return x[7:0];
  endfunction

  task automatic push(input logic [31:0] w);
    mem[wr % 16] = w;
    wr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.out_ready = 0;
    rst_n = 0;
    push(32'hA1B2C3D4);
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got %b want 0", bus.out_last); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset out_data got %h want 00", bus.out_data); end
    checks++; if (bus.fifo_read_en !== 1'b0) begin errors++; $display("FAIL reset fifo_read_en got %b want 0", bus.fifo_read_en); end
  endtask

  task automatic test_basic();
    cyc_t t [6] = '{
      '{1,0,1,0,0,1,32'h0,2'd0},
      '{1,0,1,1,0,0,32'hA1B2C3D4,2'd0},
      '{1,0,1,1,0,0,32'hA1B2C3D4,2'd1},
      '{1,0,1,1,0,0,32'hA1B2C3D4,2'd2},
      '{1,0,1,1,1,0,32'hA1B2C3D4,2'd3},
      '{1,0,1,0,0,0,32'h0,2'd0}};
    int rd0 = rd;
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = t[i].r; flush = t[i].f; rst_n = t[i].n;
      #1;
      checks++; if (bus.out_valid !== t[i].v) begin errors++; $display("FAIL basic c%0d out_valid got %b want %b", i, bus.out_valid, t[i].v); end
      checks++; if (bus.out_last !== t[i].l) begin errors++; $display("FAIL basic c%0d out_last got %b want %b", i, bus.out_last, t[i].l); end
      checks++; if (bus.fifo_read_en !== t[i].re) begin errors++; $display("FAIL basic c%0d fifo_read_en got %b want %b", i, bus.fifo_read_en, t[i].re); end
      if (t[i].v) begin checks++; if (bus.out_data !== sl(t[i].w, t[i].k)) begin errors++; $display("FAIL basic c%0d out_data got %h want %h", i, bus.out_data, sl(t[i].w, t[i].k)); end end
      tick();
    end
    checks++; if (rd - rd0 !== 1) begin errors++; $display("FAIL basic pops got %0d want 1", rd - rd0); end
  endtask

  task automatic test_stall();
    cyc_t t [13] = '{
      '{1,0,1,0,0,1,32'h0,2'd0},
      '{1,0,1,1,0,0,32'hA1B2C3D4,2'd0},
      '{0,0,1,1,0,0,32'hA1B2C3D4,2'd1},
      '{0,0,1,1,0,0,32'hA1B2C3D4,2'd1},
      '{0,0,1,1,0,0,32'hA1B2C3D4,2'd1},
      '{1,0,1,1,0,0,32'hA1B2C3D4,2'd1},
      '{1,0,1,1,0,0,32'hA1B2C3D4,2'd2},
      '{1,0,1,1,1,1,32'hA1B2C3D4,2'd3},
      '{1,0,1,1,0,0,32'h99887766,2'd0},
      '{1,0,1,1,0,0,32'h99887766,2'd1},
      '{1,0,1,1,0,0,32'h99887766,2'd2},
      '{1,0,1,1,1,0,32'h99887766,2'd3},
      '{1,0,1,0,0,0,32'h0,2'd0}};
    push(32'hA1B2C3D4);
    push(32'h99887766);
    for (int i = 0; i < 13; i++) begin
      bus.out_ready = t[i].r; flush = t[i].f; rst_n = t[i].n;
      #1;
      checks++; if (bus.out_valid !== t[i].v) begin errors++; $display("FAIL stall c%0d out_valid got %b want %b", i, bus.out_valid, t[i].v); end
      checks++; if (bus.out_last !== t[i].l) begin errors++; $display("FAIL stall c%0d out_last got %b want %b", i, bus.out_last, t[i].l); end
      checks++; if (bus.fifo_read_en !== t[i].re) begin errors++; $display("FAIL stall c%0d fifo_read_en got %b want %b", i, bus.fifo_read_en, t[i].re); end
      if (t[i].v) begin checks++; if (bus.out_data !== sl(t[i].w, t[i].k)) begin errors++; $display("FAIL stall c%0d out_data got %h want %h", i, bus.out_data, sl(t[i].w, t[i].k)); end end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    cyc_t t [10] = '{
      '{1,0,1,0,0,1,32'h0,2'd0},
      '{1,0,1,1,0,0,32'h11223344,2'd0},
      '{1,0,1,1,0,0,32'h11223344,2'd1},
      '{1,0,1,1,0,0,32'h11223344,2'd2},
      '{1,0,1,1,1,1,32'h11223344,2'd3},
      '{1,0,1,1,0,0,32'h55667788,2'd0},
      '{1,0,1,1,0,0,32'h55667788,2'd1},
      '{1,0,1,1,0,0,32'h55667788,2'd2},
      '{1,0,1,1,1,0,32'h55667788,2'd3},
      '{1,0,1,0,0,0,32'h0,2'd0}};
    push(32'h11223344);
    push(32'h55667788);
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = t[i].r; flush = t[i].f; rst_n = t[i].n;
      #1;
      checks++; if (bus.out_valid !== t[i].v) begin errors++; $display("FAIL b2b c%0d out_valid got %b want %b", i, bus.out_valid, t[i].v); end
      checks++; if (bus.out_last !== t[i].l) begin errors++; $display("FAIL b2b c%0d out_last got %b want %b", i, bus.out_last, t[i].l); end
      checks++; if (bus.fifo_read_en !== t[i].re) begin errors++; $display("FAIL b2b c%0d fifo_read_en got %b want %b", i, bus.fifo_read_en, t[i].re); end
      if (t[i].v) begin checks++; if (bus.out_data !== sl(t[i].w, t[i].k)) begin errors++; $display("FAIL b2b c%0d out_data got %h want %h", i, bus.out_data, sl(t[i].w, t[i].k)); end end
      tick();
    end
  endtask

  task automatic test_flush();
    cyc_t t [9] = '{
      '{1,0,1,0,0,1,32'h0,2'd0},
      '{1,0,1,1,0,0,32'hA1B2C3D4,2'd0},
      '{1,1,1,1,0,0,32'hA1B2C3D4,2'd1},
      '{1,0,1,0,0,1,32'h0,2'd0},
      '{1,0,1,1,0,0,32'hCAFEF00D,2'd0},
      '{1,0,1,1,0,0,32'hCAFEF00D,2'd1},
      '{1,0,1,1,0,0,32'hCAFEF00D,2'd2},
      '{1,0,1,1,1,0,32'hCAFEF00D,2'd3},
      '{1,0,1,0,0,0,32'h0,2'd0}};
    push(32'hA1B2C3D4);
    push(32'hCAFEF00D);
    for (int i = 0; i < 9; i++) begin
      bus.out_ready = t[i].r; flush = t[i].f; rst_n = t[i].n;
      #1;
      checks++; if (bus.out_valid !== t[i].v) begin errors++; $display("FAIL flush c%0d out_valid got %b want %b", i, bus.out_valid, t[i].v); end
      checks++; if (bus.out_last !== t[i].l) begin errors++; $display("FAIL flush c%0d out_last got %b want %b", i, bus.out_last, t[i].l); end
      checks++; if (bus.fifo_read_en !== t[i].re) begin errors++; $display("FAIL flush c%0d fifo_read_en got %b want %b", i, bus.fifo_read_en, t[i].re); end
      if (t[i].v) begin checks++; if (bus.out_data !== sl(t[i].w, t[i].k)) begin errors++; $display("FAIL flush c%0d out_data got %h want %h", i, bus.out_data, sl(t[i].w, t[i].k)); end end
      tick();
    end
    flush = 0;
  endtask

  task automatic test_reset_mid_word();
    cyc_t t [9] = '{
      '{1,0,1,0,0,1,32'h0,2'd0},
      '{1,0,1,1,0,0,32'h12345678,2'd0},
      '{1,0,0,1,0,0,32'h12345678,2'd1},
      '{1,0,1,0,0,1,32'h0,2'd0},
      '{1,0,1,1,0,0,32'h9ABCDEF0,2'd0},
      '{1,0,1,1,0,0,32'h9ABCDEF0,2'd1},
      '{1,0,1,1,0,0,32'h9ABCDEF0,2'd2},
      '{1,0,1,1,1,0,32'h9ABCDEF0,2'd3},
      '{1,0,1,0,0,0,32'h0,2'd0}};
    push(32'h12345678);
    push(32'h9ABCDEF0);
    for (int i = 0; i < 9; i++) begin
      bus.out_ready = t[i].r; flush = t[i].f; rst_n = t[i].n;
      #1;
      checks++; if (bus.out_valid !== t[i].v) begin errors++; $display("FAIL rstmid c%0d out_valid got %b want %b", i, bus.out_valid, t[i].v); end
      checks++; if (bus.out_last !== t[i].l) begin errors++; $display("FAIL rstmid c%0d out_last got %b want %b", i, bus.out_last, t[i].l); end
      checks++; if (bus.fifo_read_en !== t[i].re) begin errors++; $display("FAIL rstmid c%0d fifo_read_en got %b want %b", i, bus.fifo_read_en, t[i].re); end
      if (t[i].v) begin checks++; if (bus.out_data !== sl(t[i].w, t[i].k)) begin errors++; $display("FAIL rstmid c%0d out_data got %h want %h", i, bus.out_data, sl(t[i].w, t[i].k)); end end
      tick();
    end
    rst_n = 1;
  endtask

  initial begin
    bus.out_ready = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid_word();
    checks++; if (rd !== wr) begin errors++; $display("FAIL fifo_drained rd %0d want %0d", rd, wr); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
